studio2_keypad: RTL and testbench
=================================

// Module: studio2_keypad
// PURPOSE
//  Converts the PS/2 key event word into the two Studio II 10-key hex keypads.
//  It sits directly upstream of the rcastudioii core's keypad input.
//  The CPU latches a key number via OUT 2; the block returns per-pad "key down" on EF3 (pad 1) and EF4 (pad 2).
//  Short taps are stretched so that the game's polling loop cannot miss them.
// PARAMETERS
//  HOLD_CYCLES  960000  minimum visible press time, in clk_sys cycles (20 ms @ 48 MHz)
//  HOLD_W       20      width of each pad hold timer; must satisfy HOLD_CYCLES < 2**HOLD_W
// PORTS
//  clk_sys     in   1   system clock
//  reset       in   1   asynchronous, active-high reset
//  ps2_key     in   11  [10] event toggle, [9] pressed, [8] extended, [7:0] scancode
//  key_sel_we  in   1   one-cycle strobe from the CPU OUT 2 latch
//  key_sel     in   4   key number to test, valid when key_sel_we=1
//  ef3         out  1   pad 1 key[sel] down, active-high (core inverts)
//  ef4         out  1   pad 2 key[sel] down, active-high
//  keys_p1     out  16  visible pad 1 state, bit k = key k; bits 15:10 are always 0
//  keys_p2     out  16  visible pad 2 state, same layout as keys_p1
// BEHAVIOUR
//  Reset state
//   - All outputs 0.
//   - sel_q, down, sticky and both timers cleared.
//   - primed=0.
//  Input stage
//   - ps2_key is registered into ps2_q each cycle.
//   - While primed=0: copy ps2_q[10] into old_stb, set primed=1, and raise no event.
//     This absorbs a toggle level already present at reset release.
//  Event detection
//   - Event = primed & (ps2_q[10] != old_stb).
//   - old_stb <= ps2_q[10] every cycle.
//   - On an event with ps2_q[8]=1 (extended code): no effect.
//  Key map, non-extended scancodes
//   - Pad 1, keys 0..9: 45,16,1E,26,25,2E,36,3D,3E,46.
//   - Pad 2, keypad 0..9: 70,69,72,7A,6B,73,74,6C,75,7D.
//   - Unmapped codes: no effect.
//  Press event (bit9=1)
//   - down[k]<=1 and sticky[k]<=1.
//   - That pad's timer <= HOLD_CYCLES. Typematic repeats reload the timer.
//  Release event (bit9=0)
//   - down[k]<=0. sticky[k] is unchanged.
//   - Releasing a key that is not down has no effect.
//  Timers
//   - One per pad; decrements each cycle while nonzero.
//   - When it goes 1->0, clear all sticky bits of that pad.
//   - A press in the same cycle as expiry wins: reload the timer, keep/set sticky.
//  Visible state
//   - vis[k] = down[k] | sticky[k].
//   - keys_pX is registered.
//   - keys_pX reflects an event 3 cycles after the ps2_key toggle edge: ps2_q, then state, then output reg.
//  Select
//   - key_sel_we=1 -> sel_q <= key_sel on that edge.
//   - ef3 <= vis_p1[sel_q] and ef4 <= vis_p2[sel_q] every cycle, i.e. 1 cycle after sel_q changes.
//   - sel_q 10..15 -> ef3=ef4=0.
//  Timing guarantees
//   - A key held beyond HOLD_CYCLES stays visible via down.
//   - A tap is visible for HOLD_CYCLES cycles (±1 cycle) from its press event.
//   - Presses on both pads are fully independent; both pads may be active together.
//  Reset mid-operation
//   - Asserting reset clears all state immediately (asynchronous).
//   - After release, primed=0 again, so an in-flight toggle is ignored.
// TESTING (bench uses HOLD_CYCLES=16)
//  1. Reset, ps2_key[10]=1 held through release -> no event; keys_p1=keys_p2=0, ef3=ef4=0.
//  2. Toggle with pressed=1, code 0x26 -> keys_p1=0x0008 3 cycles later.
//     Then key_sel=3 with we -> ef3=1 next cycle, ef4=0.
//  3. Press 0x73 then release 2 cycles later -> keys_p2 bit5 stays 1 for 16 cycles, then 0.
//     ef4 follows when key_sel=5.
//  4. Hold 0x45 for 100 cycles -> keys_p1 bit0=1 throughout, clearing 3 cycles after release
//     (timer long expired).
//  5. Extended 0x70 (bit8=1), unmapped 0x1C, key_sel=12 -> keys unchanged, ef3=ef4=0.
//  6. Press 0x16 and 0x69 concurrently; assert reset at cycle 5 -> all outputs 0 immediately.
//     A toggle on the first cycle after reset is ignored.

Source files
------------

// File: rtl/studio2_keypad.sv
// PS/2 key event word to the two Studio II 10-key hex keypads.
// Taps are stretched by a per-pad hold timer so the game's polling loop cannot miss them.
module studio2_keypad #(
    parameter int HOLD_CYCLES = 960000,
    parameter int HOLD_W      = 20
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic        key_sel_we,
    input  logic [3:0]  key_sel,
    output logic        ef3,
    output logic        ef4,
    output logic [15:0] keys_p1,
    output logic [15:0] keys_p2
);

    logic [10:0]       ps2_q;
    logic              old_stb_q, old_stb_d;
    logic              primed_q, primed_d;
    logic [3:0]        sel_q, sel_d;
    logic [9:0]        down_q   [2];
    logic [9:0]        down_d   [2];
    logic [9:0]        sticky_q [2];
    logic [9:0]        sticky_d [2];
    logic [HOLD_W-1:0] timer_q  [2];
    logic [HOLD_W-1:0] timer_d  [2];
    logic [15:0]       vis_p1, vis_p2;

    logic              evt;
    logic              hit [2];
    logic [3:0]        idx;

    // Input sampler is left unreset so it keeps tracking the toggle level during
    // reset; priming then absorbs whatever level is present at release.
    always_ff @(posedge clk_sys) begin
        ps2_q <= ps2_key;
    end

    assign evt = primed_q & (ps2_q[10] != old_stb_q) & ~ps2_q[8];

    always_comb begin
        hit[0] = 1'b0;
        hit[1] = 1'b0;
        idx    = 4'd0;
        case (ps2_q[7:0])
            8'h45: begin hit[0] = 1'b1; idx = 4'd0; end
            8'h16: begin hit[0] = 1'b1; idx = 4'd1; end
            8'h1E: begin hit[0] = 1'b1; idx = 4'd2; end
            8'h26: begin hit[0] = 1'b1; idx = 4'd3; end
            8'h25: begin hit[0] = 1'b1; idx = 4'd4; end
            8'h2E: begin hit[0] = 1'b1; idx = 4'd5; end
            8'h36: begin hit[0] = 1'b1; idx = 4'd6; end
            8'h3D: begin hit[0] = 1'b1; idx = 4'd7; end
            8'h3E: begin hit[0] = 1'b1; idx = 4'd8; end
            8'h46: begin hit[0] = 1'b1; idx = 4'd9; end
            8'h70: begin hit[1] = 1'b1; idx = 4'd0; end
            8'h69: begin hit[1] = 1'b1; idx = 4'd1; end
            8'h72: begin hit[1] = 1'b1; idx = 4'd2; end
            8'h7A: begin hit[1] = 1'b1; idx = 4'd3; end
            8'h6B: begin hit[1] = 1'b1; idx = 4'd4; end
            8'h73: begin hit[1] = 1'b1; idx = 4'd5; end
            8'h74: begin hit[1] = 1'b1; idx = 4'd6; end
            8'h6C: begin hit[1] = 1'b1; idx = 4'd7; end
            8'h75: begin hit[1] = 1'b1; idx = 4'd8; end
            8'h7D: begin hit[1] = 1'b1; idx = 4'd9; end
            default: begin end
        endcase
    end

    always_comb begin
        old_stb_d = ps2_q[10];
        primed_d  = 1'b1;
        sel_d     = key_sel_we ? key_sel : sel_q;
        for (int p = 0; p < 2; p++) begin
            down_d[p]   = down_q[p];
            sticky_d[p] = sticky_q[p];
            timer_d[p]  = timer_q[p];
            if (evt && hit[p] && ps2_q[9]) begin
                // A press overrides a same-cycle expiry: other sticky bits survive too.
                down_d[p][idx]   = 1'b1;
                sticky_d[p][idx] = 1'b1;
                timer_d[p]       = HOLD_W'(HOLD_CYCLES);
            end else begin
                if (timer_q[p] != '0) begin
                    timer_d[p] = timer_q[p] - HOLD_W'(1);
                    if (timer_q[p] == HOLD_W'(1)) begin
                        sticky_d[p] = '0;
                    end
                end
                if (evt && hit[p]) begin
                    down_d[p][idx] = 1'b0;
                end
            end
        end
    end

    assign vis_p1 = {6'b0, down_q[0] | sticky_q[0]};
    assign vis_p2 = {6'b0, down_q[1] | sticky_q[1]};

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            old_stb_q <= 1'b0;
            primed_q  <= 1'b0;
            sel_q     <= 4'd0;
            ef3       <= 1'b0;
            ef4       <= 1'b0;
            keys_p1   <= 16'd0;
            keys_p2   <= 16'd0;
            for (int p = 0; p < 2; p++) begin
                down_q[p]   <= '0;
                sticky_q[p] <= '0;
                timer_q[p]  <= '0;
            end
        end else begin
            old_stb_q <= old_stb_d;
            primed_q  <= primed_d;
            sel_q     <= sel_d;
            ef3       <= vis_p1[sel_q];
            ef4       <= vis_p2[sel_q];
            keys_p1   <= vis_p1;
            keys_p2   <= vis_p2;
            for (int p = 0; p < 2; p++) begin
                down_q[p]   <= down_d[p];
                sticky_q[p] <= sticky_d[p];
                timer_q[p]  <= timer_d[p];
            end
        end
    end

endmodule

// File: tb/tb_studio2_keypad.sv
// Directed bench for studio2_keypad with a 16-cycle hold time.
module tb_studio2_keypad;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic        key_sel_we;
    logic [3:0]  key_sel;
    logic        ef3, ef4;
    logic [15:0] keys_p1, keys_p2;

    logic        tog;
    int          n_checks = 0;
    int          n_pass   = 0;

    studio2_keypad #(.HOLD_CYCLES(16), .HOLD_W(20)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ps2_key    (ps2_key),
        .key_sel_we (key_sel_we),
        .key_sel    (key_sel),
        .ef3        (ef3),
        .ef4        (ef4),
        .keys_p1    (keys_p1),
        .keys_p2    (keys_p2)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic send_key(input logic pressed, input logic ext, input logic [7:0] code);
        tog     = ~tog;
        ps2_key = {tog, pressed, ext, code};
    endtask

    task automatic select(input logic [3:0] k);
        key_sel    = k;
        key_sel_we = 1'b1;
        tick();
        key_sel_we = 1'b0;
        key_sel    = 4'd0;
        tick();
    endtask

    initial begin
        // 1: toggle level high through reset, carrying a mapped press word
        tog        = 1'b1;
        ps2_key    = {1'b1, 1'b1, 1'b0, 8'h45};
        key_sel_we = 1'b0;
        key_sel    = 4'd0;
        reset      = 1'b1;
        tick(4);
        reset = 1'b0;
        tick(5);
        check("rst_keys_p1", keys_p1, 16'h0000);
        check("rst_keys_p2", keys_p2, 16'h0000);
        check("rst_ef3", {15'd0, ef3}, 16'd0);
        check("rst_ef4", {15'd0, ef4}, 16'd0);

        // 2: press 0x26 -> pad1 key 3, three cycles of latency
        send_key(1'b1, 1'b0, 8'h26);
        tick(2);
        check("p26_lat2", keys_p1, 16'h0000);
        tick();
        check("p26_lat3", keys_p1, 16'h0008);
        select(4'd3);
        check("p26_ef3", {15'd0, ef3}, 16'd1);
        check("p26_ef4", {15'd0, ef4}, 16'd0);
        send_key(1'b0, 1'b0, 8'h26);
        tick(22);
        check("p26_clear", keys_p1, 16'h0000);

        // 3: tap 0x73 (pad2 key 5), release after 2 cycles; visible ticks 3..18
        select(4'd5);
        send_key(1'b1, 1'b0, 8'h73);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 2) send_key(1'b0, 1'b0, 8'h73);
            check($sformatf("tap_p2_t%0d", i), keys_p2, (i >= 3 && i <= 18) ? 16'h0020 : 16'h0000);
            check($sformatf("tap_ef4_t%0d", i), {15'd0, ef4}, (i >= 3 && i <= 18) ? 16'd1 : 16'd0);
        end

        // 4: hold 0x45 for 100 cycles
        send_key(1'b1, 1'b0, 8'h45);
        tick(3);
        check("hold_t3", keys_p1, 16'h0001);
        tick(47);
        check("hold_t50", keys_p1, 16'h0001);
        tick(50);
        check("hold_t100", keys_p1, 16'h0001);
        send_key(1'b0, 1'b0, 8'h45);
        tick(2);
        check("hold_rel2", keys_p1, 16'h0001);
        tick();
        check("hold_rel3", keys_p1, 16'h0000);

        // 5: extended and unmapped codes are ignored; selects 10..15 read 0
        send_key(1'b1, 1'b1, 8'h70);
        tick(4);
        check("ext70_p2", keys_p2, 16'h0000);
        send_key(1'b1, 1'b0, 8'h1C);
        tick(4);
        check("unmap_p1", keys_p1, 16'h0000);
        check("unmap_p2", keys_p2, 16'h0000);
        send_key(1'b1, 1'b0, 8'h25);
        tick(3);
        check("p25_p1", keys_p1, 16'h0010);
        select(4'd12);
        check("sel12_ef3", {15'd0, ef3}, 16'd0);
        check("sel12_ef4", {15'd0, ef4}, 16'd0);
        select(4'd4);
        check("sel4_ef3", {15'd0, ef3}, 16'd1);
        send_key(1'b0, 1'b0, 8'h25);
        tick(22);
        check("p25_clear", keys_p1, 16'h0000);

        // 6: both pads active, then asynchronous reset mid-operation
        select(4'd1);
        send_key(1'b1, 1'b0, 8'h16);
        tick();
        send_key(1'b1, 1'b0, 8'h69);
        tick(3);
        check("dual_p1", keys_p1, 16'h0002);
        check("dual_p2", keys_p2, 16'h0002);
        check("dual_ef3", {15'd0, ef3}, 16'd1);
        check("dual_ef4", {15'd0, ef4}, 16'd1);
        tick();
        reset = 1'b1;
        #1;
        check("mid_rst_p1", keys_p1, 16'h0000);
        check("mid_rst_p2", keys_p2, 16'h0000);
        check("mid_rst_ef", {14'd0, ef3, ef4}, 16'd0);
        send_key(1'b1, 1'b0, 8'h16);
        tick(2);
        reset = 1'b0;
        tick(6);
        check("inflight_p1", keys_p1, 16'h0000);
        send_key(1'b1, 1'b0, 8'h1E);
        tick(3);
        check("post_rst_p1", keys_p1, 16'h0004);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
